// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one CORDIC sine/cosine core among NUM_REQ angle requesters.
// Returns cos/sin tagged with the requester id, or an error response if the core never completes.
module cordic_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned BIT_SIZE = 18,
    parameter int unsigned TIMEOUT  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*BIT_SIZE-1:0] req_angle,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [BIT_SIZE-1:0]         rsp_cos,
    output logic [BIT_SIZE-1:0]         rsp_sin,
    output logic                        rsp_err,
    output logic                        busy,
    output logic                        core_init,
    output logic [BIT_SIZE-1:0]         core_angle,
    input  logic [BIT_SIZE-1:0]         core_cos,
    input  logic [BIT_SIZE-1:0]         core_sin,
    input  logic                        core_done
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     grant_id, cand;
    logic                grant_vld;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [BIT_SIZE-1:0] angle_q, angle_d;
    logic [BIT_SIZE-1:0] cos_q, cos_d, sin_q, sin_d;
    logic                err_q, err_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                init_q, init_d;
    logic [BIT_SIZE-1:0] angle_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_angle
        assign angle_arr[g] = req_angle[g*BIT_SIZE +: BIT_SIZE];
    end

    // Round-robin search starting just above the last winner
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (core_done || wait_cnt_q == CNT_W'(TIMEOUT - 1)) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant decode and next values for the job/response registers
    always_comb begin
        req_ready   = '0;
        ptr_d       = ptr_q;
        id_d        = id_q;
        angle_d     = angle_q;
        wait_cnt_d  = wait_cnt_q;
        cos_d       = cos_q;
        sin_d       = sin_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        init_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld && !rst) begin
                    req_ready[grant_id] = 1'b1;
                    ptr_d   = grant_id;
                    id_d    = grant_id;
                    angle_d = angle_arr[grant_id];
                    init_d  = 1'b1;
                end
            end
            ISSUE: wait_cnt_d = '0;
            WAIT: begin
                // done wins over a coincident timeout
                if (core_done) begin
                    cos_d       = core_cos;
                    sin_d       = core_sin;
                    err_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cos_d       = '0;
                    sin_d       = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            RESP: if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            angle_q     <= '0;
            wait_cnt_q  <= '0;
            cos_q       <= '0;
            sin_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            init_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            angle_q     <= angle_d;
            wait_cnt_q  <= wait_cnt_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            init_q      <= init_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_cos    = cos_q;
    assign rsp_sin    = sin_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != IDLE);
    assign core_init  = init_q;
    assign core_angle = angle_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a behavioural CORDIC stub (18-cycle latency or never done).
module tb_cordic_arbiter;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned ID_W     = 2;
    localparam int unsigned BIT_SIZE = 18;
    localparam int unsigned TIMEOUT  = 32;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_REQ-1:0]          req_valid = '0;
    logic [NUM_REQ*BIT_SIZE-1:0] req_angle = '0;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        rsp_valid;
    logic                        rsp_ready = 1'b1;
    logic [ID_W-1:0]             rsp_id;
    logic [BIT_SIZE-1:0]         rsp_cos, rsp_sin;
    logic                        rsp_err, busy, core_init;
    logic [BIT_SIZE-1:0]         core_angle, core_cos, core_sin;
    logic                        core_done = 1'b0;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  core_cnt = 0;
    bit  never_done = 1'b0;
    logic [BIT_SIZE-1:0] core_a_q = '0;

    always #5 clk = ~clk;

    cordic_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .BIT_SIZE(BIT_SIZE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_err(rsp_err), .busy(busy),
        .core_init(core_init), .core_angle(core_angle),
        .core_cos(core_cos), .core_sin(core_sin), .core_done(core_done)
    );

    // Core results: ideal Q2.16 values for the reference angles, a simple bijection otherwise
    function automatic logic [17:0] model_cos(input logic [17:0] a);
        case (a)
            18'h00000: return 18'h10000;
            18'h0C910: return 18'h0B505;
            18'h336F0: return 18'h0B505;
            default:   return ~a;
        endcase
    endfunction

    function automatic logic [17:0] model_sin(input logic [17:0] a);
        case (a)
            18'h00000: return 18'h00000;
            18'h0C910: return 18'h0B505;
            18'h336F0: return 18'h34AFB;
            default:   return a;
        endcase
    endfunction

    // done rises 18 edges after init is sampled and stays high until the next init
    always @(posedge clk) begin
        if (core_init) begin
            core_a_q  <= core_angle;
            core_cnt  <= 18;
            core_done <= 1'b0;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1 && !never_done) core_done <= 1'b1;
        end
    end
    assign core_cos = model_cos(core_a_q);
    assign core_sin = model_sin(core_a_q);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] fill_angles(input int slot, input logic [17:0] a);
        logic [71:0] v;
        for (int i = 0; i < 4; i++) v[i*18 +: 18] = 18'h2A000 + 18'(i);
        v[slot*18 +: 18] = a;
        return v;
    endfunction

    // One job: wait for grant, check issue pulse, count latency, check response fields
    task automatic run_job(input string tag, input logic [3:0] valid, input logic [71:0] angles,
                           input logic [3:0] exp_ready, input bit keep, input int exp_lat,
                           input logic exp_err, input logic [17:0] exp_cos, input logic [17:0] exp_sin);
        int n;
        int lat;
        int idx;
        logic [17:0] exp_ang;
        idx = 0;
        for (int i = 0; i < 4; i++) if (exp_ready[i]) idx = i;
        exp_ang   = angles[idx*18 +: 18];
        req_angle = angles;
        req_valid = valid;
        #1;
        n = 0;
        while (req_ready == '0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_grant"}, 32'(req_ready), 32'(exp_ready));
        if (req_ready == '0) return;
        @(posedge clk); #1;
        if (!keep) req_valid = '0;
        check({tag, "_init"}, 32'(core_init), 32'(1));
        check({tag, "_core_angle"}, 32'(core_angle), 32'(exp_ang));
        check({tag, "_busy"}, 32'(busy), 32'(1));
        @(posedge clk); #1;
        check({tag, "_init_pulse"}, 32'(core_init), 32'(0));
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_id"}, 32'(rsp_id), 32'(idx));
        check({tag, "_cos"}, 32'(rsp_cos), 32'(exp_cos));
        check({tag, "_sin"}, 32'(rsp_sin), 32'(exp_sin));
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        if (rsp_ready) begin
            @(posedge clk); #1;
            check({tag, "_rsp_done"}, 32'(rsp_valid), 32'(0));
            check({tag, "_idle"}, 32'(busy), 32'(0));
        end
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [17:0] ang;
        logic [3:0]  exp_ready;
        logic [17:0] exp_cos;
        logic [17:0] exp_sin;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [71:0] ang;
        int          slot;
        logic [17:0] a;

        // Pointer starts at 3; each row's grant follows from the previous winner
        vecs[0] = '{4'b0001, 18'h00000, 4'b0001, 18'h10000, 18'h00000};
        vecs[1] = '{4'b0100, 18'h0C910, 4'b0100, 18'h0B505, 18'h0B505};
        vecs[2] = '{4'b0100, 18'h336F0, 4'b0100, 18'h0B505, 18'h34AFB};
        vecs[3] = '{4'b1010, 18'h0C910, 4'b1000, 18'h0B505, 18'h0B505};
        vecs[4] = '{4'b1010, 18'h00000, 4'b0010, 18'h10000, 18'h00000};
        vecs[5] = '{4'b1001, 18'h336F0, 4'b1000, 18'h0B505, 18'h34AFB};
        vecs[6] = '{4'b0011, 18'h12345, 4'b0001, 18'h2DCBA, 18'h12345};
        vecs[7] = '{4'b0111, 18'h00000, 4'b0010, 18'h10000, 18'h00000};
        vecs[8] = '{4'b1101, 18'h3FFFF, 4'b0100, 18'h00000, 18'h3FFFF};

        // Reset state with every requester valid
        rst = 1'b1;
        req_valid = 4'hF;
        req_angle = fill_angles(0, 18'h01234);
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_err", 32'(rsp_err), 32'(0));
        check("rst_rsp_id", 32'(rsp_id), 32'(0));
        check("rst_rsp_cos", 32'(rsp_cos), 32'(0));
        check("rst_rsp_sin", 32'(rsp_sin), 32'(0));
        check("rst_core_init", 32'(core_init), 32'(0));
        check("rst_core_angle", 32'(core_angle), 32'(0));
        rst = 1'b0;
        #1;
        check("rst_first_grant", 32'(req_ready), 32'(4'b0001));
        req_valid = '0;
        @(posedge clk); #1;
        check("no_accept_after_drop", 32'(busy), 32'(0));

        for (int i = 0; i < 9; i++) begin
            slot = 0;
            for (int b = 0; b < 4; b++) if (vecs[i].exp_ready[b]) slot = b;
            run_job($sformatf("vec%0d", i), vecs[i].valid, fill_angles(slot, vecs[i].ang),
                    vecs[i].exp_ready, 1'b0, 20, 1'b0, vecs[i].exp_cos, vecs[i].exp_sin);
        end

        // Response back-pressure: fields held, no grant, no new init
        rsp_ready = 1'b0;
        run_job("hold", 4'hF, fill_angles(3, 18'h0C910), 4'b1000, 1'b1, 20, 1'b0,
                18'h0B505, 18'h0B505);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'(1));
            check("hold_id", 32'(rsp_id), 32'(3));
            check("hold_cos", 32'(rsp_cos), 32'(18'h0B505));
            check("hold_sin", 32'(rsp_sin), 32'(18'h0B505));
            check("hold_err", 32'(rsp_err), 32'(0));
            check("hold_req_ready", 32'(req_ready), 32'(0));
            check("hold_init", 32'(core_init), 32'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release_valid", 32'(rsp_valid), 32'(0));
        check("hold_next_grant", 32'(req_ready), 32'(4'b0001));
        req_valid = '0;

        // Watchdog timeout, then a normal job
        never_done = 1'b1;
        run_job("tmo", 4'b0100, fill_angles(2, 18'h0C910), 4'b0100, 1'b0, 33, 1'b1,
                18'h00000, 18'h00000);
        never_done = 1'b0;
        run_job("after_tmo", 4'b0001, fill_angles(0, 18'h00000), 4'b0001, 1'b0, 20, 1'b0,
                18'h10000, 18'h00000);

        // Reset while waiting on the core
        req_angle = fill_angles(1, 18'h0C910);
        req_valid = 4'b0010;
        #1;
        check("rstw_grant", 32'(req_ready), 32'(4'b0010));
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        check("rstw_busy_before", 32'(busy), 32'(1));
        req_valid = 4'b1010;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstw_req_ready", 32'(req_ready), 32'(0));
        check("rstw_busy", 32'(busy), 32'(0));
        check("rstw_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rstw_init", 32'(core_init), 32'(0));
        rst = 1'b0;
        #1;
        check("rstw_ptr_reset", 32'(req_ready), 32'(4'b0010));
        run_job("rstw_job", 4'b1010, fill_angles(1, 18'h336F0), 4'b0010, 1'b0, 20, 1'b0,
                18'h0B505, 18'h34AFB);
        run_job("to_ptr3", 4'b1000, fill_angles(3, 18'h12345), 4'b1000, 1'b0, 20, 1'b0,
                18'h2DCBA, 18'h12345);

        // All requesters held valid: strict rotation 0,1,2,3,0,1
        for (int i = 0; i < 4; i++) ang[i*18 +: 18] = 18'h01000 * 18'(i + 1);
        for (int j = 0; j < 6; j++) begin
            slot = j % 4;
            a = ang[slot*18 +: 18];
            run_job($sformatf("rr%0d", j), 4'hF, ang, 4'(1 << slot), 1'b1, 20, 1'b0, ~a, a);
        end
        req_valid = '0;
        @(posedge clk); #1;
        check("final_idle", 32'(busy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
